// File: rtl/pipe_stage_reg_pkg.sv
// rtl/pipe_stage_reg_pkg.sv - shared pipeline types and per-stage payload widths
package pipe_stage_reg_pkg;

    // Stage occupancy: nothing held, main entry held, main and skid entries held
    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FULL     = 2'd1,
        SKIDFULL = 2'd2
    } pipe_state_t;

    // Packed payload widths carried between the RISC-V pipeline stages
    localparam int IF_ID_W  = 64;
    localparam int ID_EX_W  = 160;
    localparam int EX_MEM_W = 112;
    localparam int MEM_WB_W = 72;

    // True when the main entry holds a payload for the downstream stage
    function automatic logic holds_payload(input pipe_state_t s);
        return s != EMPTY;
    endfunction

endpackage

// File: rtl/data_reg_en.sv
// rtl/data_reg_en.sv - N-bit enable register with async reset and synchronous clear
module data_reg_en #(
    parameter int           N           = 32,
    parameter logic [N-1:0] START_VALUE = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    // Clear beats load so a flush always returns the entry to its start value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= START_VALUE;
        end else if (clr) begin
            q <= START_VALUE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage with flush and optional skid entry
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int           N           = 32,
    parameter logic [N-1:0] START_VALUE = '0,
    parameter bit           SKID        = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data
);

    pipe_state_t  state;
    pipe_state_t  state_nxt;
    logic         in_ready_q;
    logic         in_fire;
    logic         out_fire;
    logic         load_main;
    logic         load_skid;
    logic         main_from_skid;
    logic [N-1:0] main_d;
    logic [N-1:0] skid_data;
    logic         skid_valid;

    // State register; in_ready_q looks ahead so it is low exactly while SKIDFULL
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
        end else if (flush) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != SKIDFULL);
        end
    end

    // Next-state and entry-load decisions from the handshake outcome
    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_nxt = FULL;
                    load_main = 1'b1;
                end
            end
            FULL: begin
                if (in_fire && out_fire) begin
                    load_main = 1'b1;
                end else if (in_fire) begin
                    // Only reachable with a skid entry: park the younger payload
                    if (SKID) begin
                        state_nxt = SKIDFULL;
                        load_skid = 1'b1;
                    end
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end
            end
            SKIDFULL: begin
                if (out_fire) begin
                    state_nxt      = FULL;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Handshake outputs; without a skid entry ready is the classic combinational form
    always_comb begin
        out_valid  = holds_payload(state);
        skid_valid = (state == SKIDFULL);
        in_ready   = SKID ? in_ready_q : (!out_valid || out_ready);
        in_fire    = in_valid && in_ready;
        out_fire   = out_valid && out_ready;
        main_d     = main_from_skid ? skid_data : in_data;
    end

    data_reg_en #(
        .N           (N),
        .START_VALUE (START_VALUE)
    ) u_main (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .en    (load_main),
        .d     (main_d),
        .q     (out_data)
    );

    data_reg_en #(
        .N           (N),
        .START_VALUE (START_VALUE)
    ) u_skid (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .en    (load_skid && !skid_valid),
        .d     (in_data),
        .q     (skid_data)
    );

endmodule
